rf_burst_port: RTL
==================

Name: rf_burst_port

Overview:
Burst access controller that acts as the initiator side of the 16x8 register file port set (two combinational read ports src0/src1, one registered write port dst/we/data).
- Accepts host commands over valid/ready and sequences multi-register writes or reads with address wrap.
- Write data arrives as a stream; read data is returned through a 2-entry output buffer.
- Sits between a debug/load host and the register file; used for register preload and state dump.

Parameters:
DW, 8, register data width
AW, 4, register address width (16 registers)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready; high only in IDLE
cmd_wr  in  1  1=write burst, 0=read burst
cmd_addr  in  AW  start register
cmd_len  in  AW  beats minus one (0..15 -> 1..16 beats)
wdata_valid  in  1  write beat offered
wdata_ready  out  1  write beat accepted when valid&ready
wdata  in  DW  write beat data
rdata_valid  out  1  read beat available
rdata_ready  in  1  host takes beat when valid&ready
rdata  out  DW  read beat data
rdata_last  out  1  marks final beat of a read burst
busy  out  1  high in any state other than IDLE
rf_src0  out  AW  register file read address 0
rf_src1  out  AW  register file read address 1
rf_dst  out  AW  register file write address
rf_we  out  1  register file write enable
rf_wdata  out  DW  register file write data
rf_data0  in  DW  combinational read data for rf_src0
rf_data1  in  DW  combinational read data for rf_src1

Behaviour:
- Clocking and reset: one clock (clk). Reset is rst_n, asynchronous and active-low. While rst_n is low, state=IDLE, the FIFO is flushed, and the counters and pointers are cleared.
- Reset values: cmd_ready=1, busy=0, wdata_ready=0, rdata_valid=0, rdata_last=0, rdata=0, rf_we=0, rf_src0=0, rf_src1=0, rf_dst=0, rf_wdata=0.
- Reset mid-burst: abandons the burst immediately; no further rf_we pulse.
- States: IDLE, WRITE, WFLUSH, READ.
- IDLE:
  - cmd accept latches ptr=cmd_addr, remaining=cmd_len+1 (5-bit).
  - Next state is WRITE if cmd_wr=1, else READ.
- WRITE:
  - wdata_ready=1.
  - Beat accepted in cycle N -> cycle N+1: rf_we=1, rf_dst=ptr, rf_wdata=beat. ptr<=ptr+1 mod 16, remaining decrements.
  - rf_we=0 in any cycle following no accepted beat.
  - Accepting the final beat -> WFLUSH.
- WFLUSH: one cycle carrying the final rf_we pulse, then IDLE. The register file is therefore updated before any following command can be accepted (read-after-write safe).
- READ fetch:
  - rf_src0 and rf_src1 are registered, holding ptr and ptr+1 mod 16.
  - Each cycle, fetch into a 2-entry FIFO:
    - 2 entries (rf_data0 then rf_data1) if 2 slots are free after this cycle's pop and remaining>=2;
    - else 1 entry (rf_data0) if 1 slot is free and remaining>=1;
    - else none.
  - ptr and remaining advance by the number fetched. rf_src updates the next cycle.
  - First fetch occurs in the cycle after command accept, once rf_src is valid.
- READ output:
  - rdata and rdata_valid come from the FIFO head.
  - rdata_last=1 on the entry fetched with remaining reaching 0.
  - Simultaneous push and pop permitted.
  - rdata_ready=0 holds rdata/rdata_valid/rdata_last stable.
  - Back to IDLE in the cycle after the last beat is popped.
- Address wrap: 15 -> 0 for both write and read bursts; a 16-beat burst from any start covers all registers once.
- In IDLE: rf_we=0; rf_src0, rf_src1, rf_dst and rf_wdata hold their last values. cmd_wr/addr/len are ignored unless cmd_valid&cmd_ready.
- Throughput: writes 1 beat/clk. Reads up to 1 beat/clk sustained with rdata_ready=1; first rdata_valid 2 cycles after command accept.

Test Plan:
- Reset then read burst addr=8 len=5, rdata_ready=1 -> rdata 0,1,0,0,0,20; rdata_last on beat 6; first rdata_valid 2 clks after accept; busy drops after last.
- Write addr=14 len=3 data A1,A2,A3,A4 -> rf_we pulses dst 14,15,0,1, each 1 clk after its beat. Read back addr=14 len=3 -> A1,A2,A3,A4.
- Write addr=3 len=0 data 5A, read addr=3 len=0 issued as early as cmd_ready allows -> rdata=5A, rdata_last=1 (no stale value).
- Read len=15 with rdata_ready toggling 1,0,0,1 pattern -> all 16 beats in address order, none dropped or duplicated; rdata stable while ready=0; FIFO never overflows.
- Write burst len=7 with wdata_valid gaps -> rf_we only in cycles after accepted beats; cmd_ready=0 throughout until after WFLUSH.
- Assert rst_n low mid write at beat 3 of 8 -> rf_we=0 immediately, cmd_ready=1, busy=0; a new read command is accepted normally after release.

Source files
------------

// File: rtl/rf_burst_port.sv
// rtl/rf_burst_port.sv - burst initiator for a 16x8 register file port set
//
// Accepts write/read burst commands from a host and drives the register
// file's two combinational read ports and single registered write port.
// Burst addresses wrap modulo 2**AW. Read data passes through a 2-entry FIFO.
//
// Ports:
//   clk, rst_n                          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_wr          command handshake, 1=write 0=read
//   cmd_addr/cmd_len                    start register, beats minus one
//   wdata_valid/wdata_ready/wdata       write beat stream
//   rdata_valid/rdata_ready/rdata       read beat stream
//   rdata_last                          final beat of a read burst
//   busy                                high whenever not idle
//   rf_src0/rf_src1/rf_data0/rf_data1   register file read ports
//   rf_dst/rf_we/rf_wdata               register file write port
module rf_burst_port #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_wr,
   input  logic [AW-1:0] cmd_addr,
   input  logic [AW-1:0] cmd_len,
   input  logic          wdata_valid,
   output logic          wdata_ready,
   input  logic [DW-1:0] wdata,
   output logic          rdata_valid,
   input  logic          rdata_ready,
   output logic [DW-1:0] rdata,
   output logic          rdata_last,
   output logic          busy,
   output logic [AW-1:0] rf_src0,
   output logic [AW-1:0] rf_src1,
   output logic [AW-1:0] rf_dst,
   output logic          rf_we,
   output logic [DW-1:0] rf_wdata,
   input  logic [DW-1:0] rf_data0,
   input  logic [DW-1:0] rf_data1
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WRITE  = 2'd1,
      S_WFLUSH = 2'd2,
      S_READ   = 2'd3
   } state_t;

   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   REM_ZERO = 0;
   localparam logic [AW:0]   REM_ONE  = 1;
   localparam logic [AW:0]   REM_TWO  = 2;

   state_t        state;
   logic [AW-1:0] ptr;
   logic [AW:0]   remaining;

   // Read FIFO: two slots, each carrying data plus its end-of-burst flag.
   logic [DW-1:0] fifo_data [2];
   logic          fifo_last [2];
   logic          rd_idx;
   logic          wr_idx;
   logic [1:0]    count;

   logic          pop;
   logic [1:0]    free_after;
   logic [AW:0]   fetch_n;
   logic [AW-1:0] ptr_next;

   assign rdata_valid = (count != 2'd0);
   assign rdata       = fifo_data[rd_idx];
   assign rdata_last  = rdata_valid & fifo_last[rd_idx];

   // Fetch sizing looks at slots free after this cycle's pop so that a
   // steady ready=1 stream sustains one beat per clock.
   always_comb begin
      pop        = rdata_valid & rdata_ready;
      free_after = 2'd2 - count + {1'b0, pop};
      fetch_n    = REM_ZERO;
      if (state == S_READ) begin
         if (free_after == 2'd2 && remaining >= REM_TWO)
            fetch_n = REM_TWO;
         else if (free_after != 2'd0 && remaining != REM_ZERO)
            fetch_n = REM_ONE;
      end
      ptr_next = ptr + fetch_n[AW-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         cmd_ready    <= 1'b1;
         busy         <= 1'b0;
         wdata_ready  <= 1'b0;
         ptr          <= '0;
         remaining    <= '0;
         rf_we        <= 1'b0;
         rf_dst       <= '0;
         rf_wdata     <= '0;
         rf_src0      <= '0;
         rf_src1      <= '0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last[0] <= 1'b0;
         fifo_last[1] <= 1'b0;
         rd_idx       <= 1'b0;
         wr_idx       <= 1'b0;
         count        <= 2'd0;
      end else begin
         rf_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  ptr       <= cmd_addr;
                  remaining <= {1'b0, cmd_len} + REM_ONE;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (cmd_wr) begin
                     state       <= S_WRITE;
                     wdata_ready <= 1'b1;
                  end else begin
                     // Read addresses are loaded now so the first fetch can
                     // happen in the very next cycle.
                     state   <= S_READ;
                     rf_src0 <= cmd_addr;
                     rf_src1 <= cmd_addr + PTR_ONE;
                  end
               end
            end

            S_WRITE: begin
               if (wdata_valid) begin
                  rf_we     <= 1'b1;
                  rf_dst    <= ptr;
                  rf_wdata  <= wdata;
                  ptr       <= ptr + PTR_ONE;
                  remaining <= remaining - REM_ONE;
                  if (remaining == REM_ONE) begin
                     state       <= S_WFLUSH;
                     wdata_ready <= 1'b0;
                  end
               end
            end

            // Carries the final write pulse so the register file is updated
            // before the next command can be accepted.
            S_WFLUSH: begin
               state     <= S_IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
            end

            S_READ: begin
               ptr       <= ptr_next;
               remaining <= remaining - fetch_n;
               rf_src0   <= ptr_next;
               rf_src1   <= ptr_next + PTR_ONE;
               if (pop)
                  rd_idx <= ~rd_idx;
               // A double fetch only happens with the FIFO empty after pop,
               // so both slots are written and wr_idx wraps back to itself.
               if (fetch_n == REM_TWO) begin
                  fifo_data[wr_idx]  <= rf_data0;
                  fifo_last[wr_idx]  <= 1'b0;
                  fifo_data[~wr_idx] <= rf_data1;
                  fifo_last[~wr_idx] <= (remaining == REM_TWO);
               end else if (fetch_n == REM_ONE) begin
                  fifo_data[wr_idx] <= rf_data0;
                  fifo_last[wr_idx] <= (remaining == REM_ONE);
                  wr_idx            <= ~wr_idx;
               end
               count <= count - {1'b0, pop} + fetch_n[1:0];
               if (pop && fifo_last[rd_idx]) begin
                  state     <= S_IDLE;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
